// File: rtl/ring_pkg.sv
// ring_pkg
// Shared definitions for the ring position tracker:
//   - state_t     : tracker FSM states (SYNC, TRACK, FAULT)
//   - ERR_*       : err_code values
//   - *_DEF       : default ring geometry (width, slot count, first slot bit, stride)
// Optional feature macro used by ring_pos_tracker: RING_REV_COUNT_EN.
package ring_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_STEP    = 2'b10;

  localparam int RING_W_DEF = 15;
  localparam int SLOTS_DEF  = 5;
  localparam int FIRST_DEF  = 1;
  localparam int STRIDE_DEF = 3;
  localparam int REV_W_DEF  = 8;

endpackage

// File: rtl/ring_slot_decode.sv
// ring_slot_decode
// Purely combinational decode of a ring vector into {legal, index}.
// A pattern is legal when exactly one slot bit (bit FIRST+k*STRIDE) is set
// and every non-slot bit is clear; index is then that slot's k.
// Ports:
//   ring  [RING_W-1:0] in  : sampled ring vector
//   legal              out : pattern is a valid one-hot slot pattern
//   index [2:0]        out : slot number of the set slot bit (0 when none)
module ring_slot_decode
  import ring_pkg::*;
#(
  parameter int RING_W = RING_W_DEF,
  parameter int SLOTS  = SLOTS_DEF,
  parameter int FIRST  = FIRST_DEF,
  parameter int STRIDE = STRIDE_DEF
) (
  input  logic [RING_W-1:0] ring,
  output logic              legal,
  output logic [2:0]        index
);

  logic [RING_W-1:0] slot_mask;
  int                hits;

  always_comb begin
    slot_mask = '0;
    hits      = 0;
    index     = 3'd0;
    for (int k = 0; k < SLOTS; k++) begin
      slot_mask[FIRST + k*STRIDE] = 1'b1;
      if (ring[FIRST + k*STRIDE]) begin
        hits  = hits + 1;
        index = k[2:0];
      end
    end
    // Any stray bit outside the slot positions makes the pattern illegal.
    legal = (hits == 1) && ((ring & ~slot_mask) == '0);
  end

endmodule

// File: rtl/ring_pos_tracker.sv
// ring_pos_tracker
// Tracks the position of a one-hot ring counter, flags illegal patterns and
// skipped/backward steps, and optionally counts completed revolutions.
// Optional feature macro: RING_REV_COUNT_EN (revolution counter; without it
// rev_cnt is constant zero and no counter flops exist).
// Ports:
//   clk                   in  : clock, rising edge
//   rst_n                 in  : synchronous active-low reset (highest priority)
//   en                    in  : sample qualifier; ring ignored when low
//   clr                   in  : synchronous clear of position/error/revolutions
//   ring      [RING_W-1:0] in : monitored ring vector
//   pos       [2:0]       out : registered slot index
//   pos_valid             out : high exactly while in TRACK
//   step                  out : one-cycle pulse on each legal one-slot advance
//   rev_cnt   [REV_W-1:0] out : saturating revolution count
//   err                   out : sticky fault flag
//   err_code  [1:0]       out : 00 none, 01 illegal pattern, 10 skip/backward
//   fsm_state             out : current FSM state, for observation
// All outputs are registered; they reflect the ring sampled on the previous edge.
module ring_pos_tracker
  import ring_pkg::*;
#(
  parameter int RING_W = RING_W_DEF,
  parameter int SLOTS  = SLOTS_DEF,
  parameter int FIRST  = FIRST_DEF,
  parameter int STRIDE = STRIDE_DEF,
  parameter int REV_W  = REV_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic [RING_W-1:0] ring,
  output logic [2:0]        pos,
  output logic              pos_valid,
  output logic              step,
  output logic [REV_W-1:0]  rev_cnt,
  output logic              err,
  output logic [1:0]        err_code,
  output state_t            fsm_state
);

  localparam logic [2:0] LAST_SLOT = 3'(SLOTS - 1);

  logic       legal;
  logic [2:0] index;
  logic [2:0] next_pos;

  ring_slot_decode #(
    .RING_W (RING_W),
    .SLOTS  (SLOTS),
    .FIRST  (FIRST),
    .STRIDE (STRIDE)
  ) u_decode (
    .ring  (ring),
    .legal (legal),
    .index (index)
  );

  assign next_pos = (pos == LAST_SLOT) ? 3'd0 : pos + 3'd1;

  // Priority: reset, then clr, then an en-qualified sample.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      fsm_state <= SYNC;
      pos       <= 3'd0;
      pos_valid <= 1'b0;
      step      <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      step <= 1'b0;
      if (en) begin
        case (fsm_state)
          SYNC: begin
            // Illegal patterns are simply waited out while acquiring lock.
            if (legal) begin
              pos       <= index;
              pos_valid <= 1'b1;
              fsm_state <= TRACK;
            end
          end
          TRACK: begin
            if (!legal) begin
              fsm_state <= FAULT;
              pos_valid <= 1'b0;
              err       <= 1'b1;
              err_code  <= ERR_ILLEGAL;
            end else if (index == pos) begin
              // Ring has not moved; hold.
            end else if (index == next_pos) begin
              pos  <= index;
              step <= 1'b1;
            end else begin
              fsm_state <= FAULT;
              pos_valid <= 1'b0;
              err       <= 1'b1;
              err_code  <= ERR_STEP;
            end
          end
          FAULT: begin
            // Sticky until clr or reset.
          end
          default: begin
            fsm_state <= SYNC;
            pos_valid <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef RING_REV_COUNT_EN
  logic wrap;

  assign wrap = en && (fsm_state == TRACK) && legal &&
                (pos == LAST_SLOT) && (index == 3'd0);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      rev_cnt <= '0;
    end else if (wrap && (rev_cnt != '1)) begin
      rev_cnt <= rev_cnt + 1'b1;
    end
  end
`else
  assign rev_cnt = '0;
`endif

endmodule

// File: doc/ring_pos_tracker.md
RING_POS_TRACKER -- requirements
Module: ring_pos_tracker

Interface
REQ-001 Parameter RING_W, default 15, SHALL set the width of the monitored ring vector.
REQ-002 Parameter SLOTS, default 5, SHALL set the number of legal one-hot slot positions.
REQ-003 Parameter FIRST, default 1, SHALL set the bit index of slot 0.
REQ-004 Parameter STRIDE, default 3, SHALL set the bit distance between slots (slot k at bit FIRST+k*STRIDE).
REQ-005 Parameter REV_W, default 8, SHALL set the revolution counter width.
REQ-006 clk  input  1  SHALL be the clock; all state SHALL update on its rising edge.
REQ-007 rst_n  input  1  SHALL be the synchronous, active-low reset.
REQ-008 en  input  1  SHALL qualify sampling; ring SHALL be ignored when en=0.
REQ-009 clr  input  1  SHALL be a synchronous clear request for error, position and revolution state.
REQ-010 ring  input  RING_W  SHALL be the monitored ring-counter vector.
REQ-011 pos  output  3  SHALL be the registered binary slot index (0..SLOTS-1).
REQ-012 pos_valid  output  1  SHALL be high only while locked and fault-free.
REQ-013 step  output  1  SHALL pulse for one cycle on each legal one-slot advance.
REQ-014 rev_cnt  output  REV_W  SHALL count completed revolutions (wrap from slot SLOTS-1 to slot 0).
REQ-015 err  output  1  SHALL be a sticky fault flag.
REQ-016 err_code  output  2  SHALL hold 00 none, 01 illegal pattern, 10 skip/backward step.

Function
REQ-017 A pattern SHALL be legal iff exactly one slot bit is 1 and every non-slot bit is 0; its index is the set slot's k.
REQ-018 The FSM SHALL have states SYNC, TRACK, FAULT.
REQ-019 In SYNC with en=1: a legal pattern SHALL load pos and move to TRACK; an illegal pattern SHALL stay in SYNC with err unchanged.
REQ-020 In TRACK with en=1: same index SHALL hold pos with step=0.
REQ-021 In TRACK with en=1: index == (pos+1) mod SLOTS SHALL update pos and assert step for one cycle.
REQ-022 The advance from SLOTS-1 to 0 SHALL also increment rev_cnt, saturating at all-ones.
REQ-023 In TRACK with en=1: an illegal pattern SHALL enter FAULT with err=1 and err_code=01.
REQ-024 In TRACK with en=1: a legal pattern with any other index SHALL enter FAULT with err=1 and err_code=10.
REQ-025 In FAULT, pos and rev_cnt SHALL hold, pos_valid=0, step=0, and the state SHALL persist until clr or reset.
REQ-026 clr=1 in any state SHALL, next cycle, enter SYNC with pos=0, pos_valid=0, step=0, rev_cnt=0, err=0, err_code=00.
REQ-027 clr SHALL override a simultaneous sample, even when en=1.
REQ-028 With en=0 and clr=0, all state and outputs SHALL hold except step, which SHALL be 0.
REQ-029 All outputs SHALL be registered, with a latency of exactly one clock from the sampled ring.
REQ-030 pos_valid SHALL be 1 exactly when the state is TRACK.

Reset
REQ-031 rst_n=0 at a clock edge SHALL force SYNC, pos=0, pos_valid=0, step=0, rev_cnt=0, err=0, err_code=00.
REQ-032 Reset SHALL have priority over clr and en, and SHALL abort any state mid-operation.

Configuration
REQ-033 Macro RING_REV_COUNT_EN, when defined, SHALL include the revolution counter per REQ-014/022.
REQ-034 Without RING_REV_COUNT_EN, rev_cnt SHALL be tied to 0 and no counter flops SHALL be generated; all other behaviour SHALL be unchanged.

Structure
REQ-035 A shared package ring_pkg SHALL hold the state enum (SYNC, TRACK, FAULT), the err_code constants, and the default RING_W, SLOTS, FIRST and STRIDE constants.
REQ-036 A combinational sub-module ring_slot_decode SHALL map ring to {legal, index}; the FSM and registers SHALL live in ring_pos_tracker.

Verification
REQ-037 Reset, then en=1 with ring=15'h0002 -> next cycle TRACK, pos=0, pos_valid=1, step=0, err=0.
REQ-038 Locked at slot 0, drive 0x0010, 0x0080, 0x0400, 0x2000, 0x0002 on successive cycles -> step on each, pos 1,2,3,4,0, rev_cnt=1.
REQ-039 Locked at pos=1, drive ring=15'h0003 (non-slot bit set) -> FAULT, err=1, err_code=01, pos_valid=0, pos holds 1.
REQ-040 Locked at pos=1, drive 0x0400 (skip) -> err_code=10; in a separate run, drive 0x0002 (backward) -> err_code=10.
REQ-041 Held in FAULT, pulse clr with en=1 and a legal ring -> SYNC with all outputs cleared; the next legal sample relocks.
REQ-042 With en=0 while ring changes illegally -> no state change; with rev_cnt at 255 and another wrap -> rev_cnt stays 255.
